// File: rtl/snes_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : snes_mem_arbiter
// Description : Shares one byte-wide external memory port between the SNES
//               CPU bus, the APU audio RAM and the ROM loader. Each client
//               may have one request outstanding. Priority is CPU > ARAM >
//               LOADER, except that an ARAM request that has waited
//               ARAM_MAXWAIT cycles beats the CPU. A stuck memory access is
//               forced to complete after ACK_TIMEOUT cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module snes_mem_arbiter #(
    parameter int ADDR_W       = 23,
    parameter int ARAM_MAXWAIT = 12,
    parameter int ACK_TIMEOUT  = 64
) (
    input  logic              MCLK,
    input  logic              RST,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_d,
    output logic [7:0]        cpu_q,
    output logic              cpu_rdy,
    input  logic              aram_req,
    input  logic              aram_we,
    input  logic [ADDR_W-1:0] aram_addr,
    input  logic [7:0]        aram_d,
    output logic [7:0]        aram_q,
    output logic              aram_rdy,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [7:0]        ldr_d,
    output logic [7:0]        ldr_q,
    output logic              ldr_rdy,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_d,
    input  logic [7:0]        mem_q,
    input  logic              mem_ack,
    output logic              busy,
    output logic [1:0]        grant,
    output logic [2:0]        err_ovf,
    output logic              err_tmo
);

    localparam int WAIT_W = $clog2(ARAM_MAXWAIT + 1);
    localparam int TMO_W  = $clog2(ACK_TIMEOUT + 1);

    localparam logic [WAIT_W-1:0] c_WAIT_MAX = WAIT_W'(ARAM_MAXWAIT);
    localparam logic [TMO_W-1:0]  c_TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_WAIT = 1'b1;

    // Grant codes double as (client index + 1): 0 CPU, 1 ARAM, 2 LOADER
    localparam logic [1:0] c_GNT_NONE = 2'd0;
    localparam logic [1:0] c_GNT_CPU  = 2'd1;
    localparam logic [1:0] c_GNT_ARAM = 2'd2;
    localparam logic [1:0] c_GNT_LDR  = 2'd3;

    // Client-indexed views of the three request ports
    logic [2:0]        w_req;
    logic [2:0]        w_we_in;
    logic [ADDR_W-1:0] w_addr_in [3];
    logic [7:0]        w_d_in    [3];

    assign w_req        = {ldr_req, aram_req, cpu_req};
    assign w_we_in      = {ldr_we, aram_we, cpu_we};
    assign w_addr_in[0] = cpu_addr;
    assign w_addr_in[1] = aram_addr;
    assign w_addr_in[2] = ldr_addr;
    assign w_d_in[0]    = cpu_d;
    assign w_d_in[1]    = aram_d;
    assign w_d_in[2]    = ldr_d;

    logic [0:0]        r_state;
    logic [2:0]        r_pend;
    logic [2:0]        r_we;
    logic [ADDR_W-1:0] r_addr [3];
    logic [7:0]        r_d    [3];
    logic [7:0]        r_q    [3];
    logic [2:0]        r_rdy;
    logic [2:0]        r_err_ovf;
    logic              r_err_tmo;
    logic [WAIT_W-1:0] r_aram_wait;
    logic [TMO_W-1:0]  r_tmo;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [7:0]        r_mem_d;
    logic [1:0]        r_grant;

    logic [0:0]        w_state_nxt;
    logic              w_issue;
    logic [1:0]        w_win;
    logic              w_done;
    logic              w_tmo_hit;
    logic [2:0]        w_gnt_oh;
    logic [2:0]        w_win_oh;
    logic [2:0]        w_ovf;
    logic [2:0]        w_cap;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [7:0]        w_sel_d;

    // State register
    always_ff @(posedge MCLK) begin
        if (RST) r_state <= c_ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next state: pick a winner in IDLE, finish on ack or timeout in WAIT
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_win       = c_GNT_NONE;
        w_done      = 1'b0;
        w_tmo_hit   = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (|r_pend) begin
                    w_issue     = 1'b1;
                    w_state_nxt = c_ST_WAIT;
                    if (r_pend[1] && (r_aram_wait == c_WAIT_MAX)) w_win = c_GNT_ARAM;
                    else if (r_pend[0])                           w_win = c_GNT_CPU;
                    else if (r_pend[1])                           w_win = c_GNT_ARAM;
                    else                                          w_win = c_GNT_LDR;
                end
            end
            c_ST_WAIT: begin
                if (mem_ack) begin
                    w_done      = 1'b1;
                    w_state_nxt = c_ST_IDLE;
                end else if (r_tmo == c_TMO_LAST) begin
                    w_done      = 1'b1;
                    w_tmo_hit   = 1'b1;
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Per-client decode: a request from a client that is already pending or
    // owns the memory is an overflow and is dropped
    always_comb begin
        w_gnt_oh = '0;
        w_win_oh = '0;
        w_ovf    = '0;
        w_cap    = '0;
        for (int c = 0; c < 3; c++) begin
            w_gnt_oh[c] = (r_grant == 2'(c + 1));
            w_win_oh[c] = (w_win == 2'(c + 1));
            w_ovf[c]    = w_req[c] & (r_pend[c] | w_gnt_oh[c]);
            w_cap[c]    = w_req[c] & ~w_ovf[c];
        end
    end

    // Latched fields of the selected winner
    always_comb begin
        w_sel_we   = r_we[0];
        w_sel_addr = r_addr[0];
        w_sel_d    = r_d[0];
        for (int c = 1; c < 3; c++) begin
            if (w_win_oh[c]) begin
                w_sel_we   = r_we[c];
                w_sel_addr = r_addr[c];
                w_sel_d    = r_d[c];
            end
        end
    end

    // Client-side registers: request capture, overflow flags, read data, ready
    always_ff @(posedge MCLK) begin
        if (RST) begin
            r_pend    <= '0;
            r_we      <= '0;
            r_rdy     <= '0;
            r_err_ovf <= '0;
            for (int c = 0; c < 3; c++) begin
                r_addr[c] <= '0;
                r_d[c]    <= '0;
                r_q[c]    <= '0;
            end
        end else begin
            for (int c = 0; c < 3; c++) begin
                r_rdy[c] <= w_done & w_gnt_oh[c];
                if (w_ovf[c]) r_err_ovf[c] <= 1'b1;
                if (w_cap[c]) begin
                    r_pend[c] <= 1'b1;
                    r_we[c]   <= w_we_in[c];
                    r_addr[c] <= w_addr_in[c];
                    r_d[c]    <= w_d_in[c];
                end else if (w_win_oh[c]) begin
                    r_pend[c] <= 1'b0;
                end
                if (w_done && w_gnt_oh[c] && !r_mem_we)
                    r_q[c] <= w_tmo_hit ? 8'hFF : mem_q;
            end
        end
    end

    // Memory-side registers, grant, timeout counter and ARAM starvation counter
    always_ff @(posedge MCLK) begin
        if (RST) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_d     <= '0;
            r_grant     <= c_GNT_NONE;
            r_tmo       <= '0;
            r_err_tmo   <= 1'b0;
            r_aram_wait <= '0;
        end else begin
            r_mem_req <= w_issue;
            if (w_issue) begin
                r_mem_we   <= w_sel_we;
                r_mem_addr <= w_sel_addr;
                r_mem_d    <= w_sel_d;
                r_grant    <= w_win;
                r_tmo      <= '0;
            end else if (w_done) begin
                r_grant <= c_GNT_NONE;
            end else if (r_state == c_ST_WAIT) begin
                r_tmo <= r_tmo + TMO_W'(1);
            end
            if (w_tmo_hit) r_err_tmo <= 1'b1;
            if (w_win_oh[1])
                r_aram_wait <= '0;
            else if (r_pend[1] && !w_gnt_oh[1] && (r_aram_wait != c_WAIT_MAX))
                r_aram_wait <= r_aram_wait + WAIT_W'(1);
        end
    end

    assign cpu_q    = r_q[0];
    assign aram_q   = r_q[1];
    assign ldr_q    = r_q[2];
    assign cpu_rdy  = r_rdy[0];
    assign aram_rdy = r_rdy[1];
    assign ldr_rdy  = r_rdy[2];
    assign mem_req  = r_mem_req;
    assign mem_we   = r_mem_we;
    assign mem_addr = r_mem_addr;
    assign mem_d    = r_mem_d;
    assign busy     = (r_state != c_ST_IDLE);
    assign grant    = r_grant;
    assign err_ovf  = r_err_ovf;
    assign err_tmo  = r_err_tmo;

endmodule
`default_nettype wire
